// File: rtl/uart_rx_frame_pkg.sv
// Shared types and helpers for the UART receive framer.
package uartRxPkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rxState_t;

   localparam int DATA_BITS_DEF = 8;
   localparam int PAR_W         = 16;

   // Data is zero-extended to PAR_W; the extra zeros do not change the XOR.
   function automatic logic parErr(input logic [PAR_W-1:0] data,
                                   input logic             parBit,
                                   input logic             odd);
      logic x;
      x = (^data) ^ parBit;
      return odd ? ~x : x;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial input, configuration and receive-strobe bundle of the UART framer.
interface uart_rx_frame_if
   import uartRxPkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) ();

   logic                 tick16;
   logic                 rxd;
   logic                 parEn;
   logic                 parOdd;
   logic [DATA_BITS-1:0] rxDat;
   logic                 rxMvDatEn;
   logic                 setPErr;
   logic                 setFErr;

   modport master (
      output tick16, rxd, parEn, parOdd,
      input  rxDat, rxMvDatEn, setPErr, setFErr
   );

   modport slave (
      input  tick16, rxd, parEn, parOdd,
      output rxDat, rxMvDatEn, setPErr, setFErr
   );

endinterface

// File: rtl/uart_rx_frame_sync.sv
// Two-flop synchroniser for the raw serial line; resets to the idle level (1).
module bitSync (
   input  logic clk,
   input  logic arst,
   input  logic async_in,
   output logic sync_out
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], async_in};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) sync_q <= 2'b11;
      else      sync_q <= sync_d;
   end

   assign sync_out = sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: 16x oversampled deserialiser with parity/stop checking.
// state  | meaning
// IDLE   | waiting for line high (arm) then a falling edge
// START  | re-checking start bit at mid-bit
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, strobes follow one clk later
module uart_rx_frame
   import uartRxPkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int MID_TICK  = 7
) (
   input  logic             clk,
   input  logic             arst,
   uart_rx_frame_if.slave   bus
);

   localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [3:0]       MID      = 4'(MID_TICK);

   logic                 rx_s;
   rxState_t             state_q,   state_d;
   logic [3:0]           cnt_q,     cnt_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 par_bit_q, par_bit_d;
   logic                 par_en_q,  par_en_d;
   logic                 par_odd_q, par_odd_d;
   logic                 armed_q,   armed_d;
   logic [DATA_BITS-1:0] rx_dat_q,  rx_dat_d;
   logic                 mv_q,      mv_d;
   logic                 perr_q,    perr_d;
   logic                 ferr_q,    ferr_d;

   bitSync u_sync (
      .clk      (clk),
      .arst     (arst),
      .async_in (bus.rxd),
      .sync_out (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_bit_d = par_bit_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      armed_d   = armed_q;
      rx_dat_d  = rx_dat_q;
      mv_d      = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               cnt_d     = 4'd0;
               par_en_d  = bus.parEn;
               par_odd_d = bus.parOdd;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bus.tick16) begin
               if (cnt_q == MID) begin
                  if (!rx_s) begin
                     cnt_d   = 4'd0;
                     idx_d   = '0;
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (bus.tick16) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     state_d = par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
         end
         ST_PARITY: begin
            if (bus.tick16) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  par_bit_d = rx_s;
                  state_d   = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (bus.tick16) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  // Strobes are registered here so they appear one clk after the stop sample.
                  rx_dat_d = shift_q;
                  mv_d     = 1'b1;
                  ferr_d   = ~rx_s;
                  perr_d   = par_en_q & parErr(PAR_W'(shift_q), par_bit_q, par_odd_q);
                  armed_d  = 1'b0;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         armed_q   <= 1'b0;
         rx_dat_q  <= '0;
         mv_q      <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_bit_q <= par_bit_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         armed_q   <= armed_d;
         rx_dat_q  <= rx_dat_d;
         mv_q      <= mv_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign bus.rxDat     = rx_dat_q;
   assign bus.rxMvDatEn = mv_q;
   assign bus.setPErr   = perr_q;
   assign bus.setFErr   = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table of frames plus break, glitch, reset and back-to-back sequences.
module tb_uart_rx_frame;
   import uartRxPkg::*;

   typedef struct {
      logic [7:0] dat;
      logic       pe;
      logic       fe;
   } exp_t;

   typedef struct {
      int         div;
      logic [7:0] dat;
      logic       pe;
      logic       po;
      logic       pb;
      logic       stop;
      logic       flip;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;

   uart_rx_frame_if #(.DATA_BITS(8)) u_if ();

   uart_rx_frame #(.DATA_BITS(8), .MID_TICK(7)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (u_if)
   );

   always #5 clk = ~clk;

   int         checks     = 0;
   int         failures   = 0;
   int         tick_div   = 4;
   int         ph         = 0;
   int         pulse_cnt  = 0;
   int         exp_pulses = 0;
   int         cyc        = 0;
   int         pulse_cyc[$];
   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] exp_last   = 8'h00;
   vec_t       vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   initial begin
      u_if.tick16 = 1'b0;
      forever begin
         @(negedge clk);
         ph = ph + 1;
         if (ph >= tick_div) ph = 0;
         u_if.tick16 = (ph == 0);
      end
   end

   // Scoreboard: every strobe pops one expected frame; between strobes nothing may change.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (arst) begin
            exp_last = 8'h00;
         end else if (u_if.rxMvDatEn) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe actual=rxDat 0x%0h required=no strobe", u_if.rxDat);
            end else begin
               mon_e = sb.pop_front();
               check("rx_dat", 32'(u_if.rxDat), 32'(mon_e.dat));
               check("set_perr", 32'(u_if.setPErr), 32'(mon_e.pe));
               check("set_ferr", 32'(u_if.setFErr), 32'(mon_e.fe));
               exp_last = mon_e.dat;
            end
         end else begin
            check("idle_err_strobes", 32'({u_if.setPErr, u_if.setFErr}), 32'd0);
            check("rx_dat_hold", 32'(u_if.rxDat), 32'(exp_last));
         end
      end
   end

   task automatic send_bit(input logic b);
      u_if.rxd = b;
      repeat (16 * tick_div) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] dat, input logic pe, input logic pb,
                             input logic stop, input logic flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(dat[i]);
         if (flip && i == 2) begin
            u_if.parEn  = ~u_if.parEn;
            u_if.parOdd = ~u_if.parOdd;
         end
      end
      if (pe) send_bit(pb);
      send_bit(stop);
   endtask

   task automatic expect_frame(input logic [7:0] dat, input logic pe, input logic fe);
      exp_t e;
      e.dat = dat;
      e.pe  = pe;
      e.fe  = fe;
      sb.push_back(e);
      exp_pulses++;
   endtask

   initial begin
      //          div  dat    pe    po    pb    stop  flip  exp_pe exp_fe
      vecs[0] = '{4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{4, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{4, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{4, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{4, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{4, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{2, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      u_if.rxd    = 1'b1;
      u_if.parEn  = 1'b0;
      u_if.parOdd = 1'b0;
      arst        = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_rx_dat", 32'(u_if.rxDat), 32'd0);
      check("reset_mv", 32'(u_if.rxMvDatEn), 32'd0);
      check("reset_perr", 32'(u_if.setPErr), 32'd0);
      check("reset_ferr", 32'(u_if.setFErr), 32'd0);
      @(negedge clk);
      arst = 1'b0;
      repeat (20) @(negedge clk);

      foreach (vecs[i]) begin
         tick_div    = vecs[i].div;
         u_if.parEn  = vecs[i].pe;
         u_if.parOdd = vecs[i].po;
         expect_frame(vecs[i].dat, vecs[i].exp_pe, vecs[i].exp_fe);
         send_frame(vecs[i].dat, vecs[i].pe, vecs[i].pb, vecs[i].stop, vecs[i].flip);
         send_bit(1'b1);
         check("vec_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
      end

      // Framing error followed by a held-low line: exactly one strobe until the line recovers.
      tick_div    = 4;
      u_if.parEn  = 1'b1;
      u_if.parOdd = 1'b1;
      expect_frame(8'h01, 1'b0, 1'b1);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) send_bit(1'b0);
      check("break_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
      send_bit(1'b1);
      u_if.parEn = 1'b0;
      expect_frame(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      send_bit(1'b1);
      check("after_break_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));

      // 4-tick glitch on an idle line is rejected as a false start.
      u_if.rxd = 1'b0;
      repeat (4 * tick_div) @(negedge clk);
      u_if.rxd = 1'b1;
      repeat (3) send_bit(1'b1);
      check("glitch_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
      check("glitch_rx_dat", 32'(u_if.rxDat), 32'h5A);

      // Reset in the middle of data bit 4 of 0xFF.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (8 * tick_div) @(negedge clk);
      arst = 1'b1;
      #1;
      check("arst_rx_dat", 32'(u_if.rxDat), 32'd0);
      check("arst_mv", 32'(u_if.rxMvDatEn), 32'd0);
      check("arst_perr", 32'(u_if.setPErr), 32'd0);
      check("arst_ferr", 32'(u_if.setFErr), 32'd0);
      repeat (3) @(negedge clk);
      arst = 1'b0;
      repeat (5) send_bit(1'b1);
      check("arst_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
      expect_frame(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      send_bit(1'b1);
      check("post_arst_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));

      // Back-to-back frames with no idle gap: strobes 160 ticks (640 clks) apart.
      begin
         int n0;
         n0 = pulse_cyc.size();
         expect_frame(8'h12, 1'b0, 1'b0);
         expect_frame(8'h34, 1'b0, 1'b0);
         send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
         send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
         send_bit(1'b1);
         check("b2b_pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
         if (pulse_cyc.size() >= n0 + 2) begin
            check("b2b_spacing", 32'(pulse_cyc[n0+1] - pulse_cyc[n0]), 32'd640);
         end else begin
            checks++;
            failures++;
            $display("FAIL b2b_spacing actual=%0d strobes required=2", pulse_cyc.size() - n0);
         end
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
